// File: rtl/i2c_target_regs.sv
// I2C target with a 4-byte register file and auto-incrementing pointer.
// Bus is oversampled on clk; sda is only ever pulled low or released.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'd85,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scl,
    inout  wire         sda,
    output logic [31:0] reg_data,
    output logic        wr_pulse,
    output logic [1:0]  wr_idx,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall;
    logic                   start_c, stop_c;

    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0][7:0] regs_q, regs_d;
    logic            rw_q, rw_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            wr_pulse_q, wr_pulse_d;
    logic [1:0]      wr_idx_q, wr_idx_d;
    logic [7:0]      rx_byte;

    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte    = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        if (start_c) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
        end else if (stop_c) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                    state_d = S_ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte[1:0];
                                state_d = S_WR_ACK;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_pulse_d    = 1'b1;
                                wr_idx_d      = ptr_q;
                                ptr_d         = ptr_q + 2'd1;
                                state_d       = S_WR_ACK;
                            end
                        end
                    end
                end
                // First fall drives the ACK low, second fall ends it.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            oe_d      = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == S_WR_ACK) begin
                                state_d = S_WR_DATA;
                            end else if (rw_q) begin
                                state_d = S_RD_DATA;
                                shift_d = regs_q[ptr_q];
                                oe_d    = ~regs_q[ptr_q][7];
                            end else begin
                                state_d = S_PTR;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            ptr_d     = ptr_q + 2'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                // bit_cnt marks a received ACK awaiting the closing fall.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = S_WAIT_STOP;
                        else       bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        shift_d   = regs_q[ptr_q];
                        oe_d      = ~regs_q[ptr_q][7];
                        state_d   = S_RD_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 2'd0;
            regs_q     <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= 2'd0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign reg_data = regs_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;
    assign busy     = busy_q;

endmodule
